limbus_sysid_checker: RTL and testbench

//  Boot-time sequencer that reads the system-ID slave over Avalon-MM, compares
//  ID (addr 0) and timestamp (addr 1) against expected values, and reports pass/fail.

---
 rtl/limbus_sysid_checker_if.sv | 9 +
 rtl/limbus_sysid_checker.sv | 79 +++++++
 tb/tb_limbus_sysid_checker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/limbus_sysid_checker_if.sv
// limbus_sysid_checker_if: Avalon-MM read bus (address, read, readdata, waitrequest) between the checker (master) and the sysid slave
interface limbus_sysid_checker_if;
  logic        av_address;
  logic        av_read;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  modport master (output av_address, av_read, input av_readdata, av_waitrequest);
  modport slave (input av_address, av_read, output av_readdata, av_waitrequest);
endinterface

// File: rtl/limbus_sysid_checker.sv
// limbus_sysid_checker: boot-time sysid ID/timestamp checker; clock/reset/start in, Avalon-MM master bus, busy/done/pass/timeout/id_word/ts_word/retry_cnt out
module limbus_sysid_checker #(
  parameter logic [31:0] EXP_ID    = 32'd0,
  parameter logic [31:0] EXP_TS    = 32'd1415705966,
  parameter int unsigned RD_LAT    = 0,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  limbus_sysid_checker_if.master        av,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [31:0]                   id_word,
  output logic [31:0]                   ts_word,
  output logic [3:0]                    retry_cnt
);
  localparam int SW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK, DONE} state_t;
  state_t state;
  logic [SW-1:0] stall_cnt;
  logic [2:0] lat_cnt;
  logic accept;
  assign av.av_read = state == RD_ID || state == RD_TS;
  assign av.av_address = state == RD_TS;
  assign accept = av.av_read && !av.av_waitrequest;
  assign busy = state inside {RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK};
  assign done = state == DONE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pass <= 1'b0;
      timeout <= 1'b0;
      id_word <= '0;
      ts_word <= '0;
      retry_cnt <= '0;
      stall_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= RD_ID;
          pass <= 1'b0;
          timeout <= 1'b0;
          retry_cnt <= '0;
        end
        RD_ID, RD_TS: if (accept) begin
          stall_cnt <= '0;
          lat_cnt <= '0;
          if (RD_LAT == 0) begin
            if (state == RD_ID) id_word <= av.av_readdata;
            else ts_word <= av.av_readdata;
            state <= state == RD_ID ? RD_TS : CHECK;
          end else state <= state == RD_ID ? WAIT_ID : WAIT_TS;
        end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
          stall_cnt <= '0;
          timeout <= 1'b1;
          state <= DONE;
        end else stall_cnt <= stall_cnt + SW'(1);
        WAIT_ID, WAIT_TS: if (lat_cnt == 3'(RD_LAT - 1)) begin
          if (state == WAIT_ID) id_word <= av.av_readdata;
          else ts_word <= av.av_readdata;
          state <= state == WAIT_ID ? RD_TS : CHECK;
        end else lat_cnt <= lat_cnt + 3'd1;
        CHECK: if (id_word == EXP_ID && ts_word == EXP_TS) begin
          pass <= 1'b1;
          state <= DONE;
        end else if (retry_cnt == 4'(MAX_RETRY)) state <= DONE;
        else begin
          retry_cnt <= retry_cnt + 4'd1;
          state <= RD_ID;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_limbus_sysid_checker.sv
// tb_limbus_sysid_checker: randomized scoreboard bench for two checker instances (RD_LAT 0 and 2)
module tb_limbus_sysid_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1415705966;
  localparam int TMO = 16;
  localparam int MR = 2;
  typedef struct {
    int inst;
    int e0;
    int lat;
    int reads;
    logic p;
    logic t;
    logic [3:0] rc;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start [2];
  logic busy [2], done [2], pass [2], tmo [2], av_read [2], av_address [2], wreq [2];
  logic [31:0] id_word [2], ts_word [2], rdata [2];
  logic [3:0] retry_cnt [2];
  logic done_prev [2] = '{1'b0, 1'b0};
  exp_t exp_q [$];
  int n_vec = 0, n_bad = 0, cyc = 0, act = 0;
  int rd_idx = 0, stall_done = 0, wait_left = 0;
  int rd_stall [6];
  logic [31:0] rd_data [6];
  logic [31:0] hold;
  logic [31:0] m_id [2], m_ts [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    limbus_sysid_checker_if bus ();
    assign bus.av_waitrequest = wreq[g];
    assign bus.av_readdata = rdata[g];
    assign av_read[g] = bus.av_read;
    assign av_address[g] = bus.av_address;
    limbus_sysid_checker #(.RD_LAT(g == 0 ? 0 : 2)) dut (
      .clock(clock), .reset(reset), .start(start[g]), .av(bus),
      .busy(busy[g]), .done(done[g]), .pass(pass[g]), .timeout(tmo[g]),
      .id_word(id_word[g]), .ts_word(ts_word[g]), .retry_cnt(retry_cnt[g]));
  end

  function automatic void cmp(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // slave: stalls each read rd_stall[r] cycles, then returns rd_data[r] on accept
  // (latency 0) or exactly lat cycles later, random garbage otherwise
  always @(negedge clock) begin
    int k, lat;
    lat = act == 0 ? 0 : 2;
    for (int i = 0; i < 2; i++) begin
      wreq[i] = 1'b0;
      rdata[i] = $urandom;
    end
    if (wait_left > 0) begin
      wait_left--;
      if (wait_left == 0) rdata[act] = hold;
    end else if (av_read[act] === 1'b1) begin
      k = rd_idx < 6 ? rd_idx : 5;
      if (stall_done < rd_stall[k]) begin
        wreq[act] = 1'b1;
        stall_done++;
      end else begin
        cmp("av_address", {31'd0, av_address[act]}, {31'd0, rd_idx[0]});
        hold = rd_idx < 6 ? rd_data[rd_idx] : $urandom;
        if (lat == 0) rdata[act] = hold;
        wait_left = lat;
        rd_idx++;
        stall_done = 0;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (done[i] === 1'b1 && done_prev[i] !== 1'b1) begin
        if (exp_q.size() == 0) cmp("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          cmp("inst", i, e.inst);
          cmp("latency", cyc - e.e0, e.lat);
          cmp("reads", rd_idx, e.reads);
          cmp("pass", {31'd0, pass[i]}, {31'd0, e.p});
          cmp("timeout", {31'd0, tmo[i]}, {31'd0, e.t});
          cmp("retry_cnt", {28'd0, retry_cnt[i]}, {28'd0, e.rc});
          cmp("id_word", id_word[i], e.id);
          cmp("ts_word", ts_word[i], e.ts);
          cmp("busy_at_done", {31'd0, busy[i]}, 32'd0);
          cmp("av_read_at_done", {31'd0, av_read[i]}, 32'd0);
        end
      end
      done_prev[i] = done[i];
    end
  end

  // reference: walk the passes in order, charging each read 1+stall+latency cycles
  function automatic exp_t model(int inst, int e0);
    exp_t e;
    logic [31:0] w [2];
    int l;
    l = inst == 0 ? 0 : 2;
    e.inst = inst; e.e0 = e0; e.lat = 0; e.reads = 0; e.p = 1'b0; e.t = 1'b0; e.rc = 4'd0;
    w[0] = m_id[inst];
    w[1] = m_ts[inst];
    for (int p = 0; p <= MR; p++) begin
      e.rc = 4'(p);
      for (int k = 0; k < 2; k++) begin
        if (rd_stall[2 * p + k] >= TMO) begin
          e.lat += TMO;
          e.t = 1'b1;
          break;
        end
        e.lat += 1 + rd_stall[2 * p + k] + l;
        w[k] = rd_data[2 * p + k];
        e.reads++;
      end
      if (e.t) break;
      e.lat += 1;
      if (w[0] == EXP_ID && w[1] == EXP_TS) begin
        e.p = 1'b1;
        break;
      end
    end
    e.id = w[0];
    e.ts = w[1];
    m_id[inst] = w[0];
    m_ts[inst] = w[1];
    return e;
  endfunction

  task automatic gen(int bad, int tr, bit quiet, int s0);
    for (int r = 0; r < 6; r++) begin
      rd_data[r] = r[0] ? EXP_TS : EXP_ID;
      rd_stall[r] = 0;
      if (!quiet) rd_stall[r] = $urandom_range(0, 4) == 0 ? $urandom_range(TMO - 2, TMO - 1) : $urandom_range(0, 3);
    end
    for (int p = 0; p < bad && p < 3; p++) begin
      int k = $urandom_range(0, 1);
      rd_data[2 * p + k] = rd_data[2 * p + k] ^ 32'($urandom_range(1, 65535));
    end
    if (tr >= 0) rd_stall[tr] = TMO + (quiet ? 0 : int'($urandom_range(0, 3)));
    if (s0 >= 0) rd_stall[0] = s0;
  endtask

  task automatic kick(int inst);
    @(posedge clock); #1;
    act = inst; rd_idx = 0; stall_done = 0; wait_left = 0;
  endtask

  task automatic pulse(int inst);
    start[inst] = 1'b1;
    @(posedge clock); #1;
    start[inst] = 1'b0;
  endtask

  task automatic run(int inst, int bad, int tr, bit quiet, int s0, bit poke);
    int n;
    kick(inst);
    gen(bad, tr, quiet, s0);
    pulse(inst);
    exp_q.push_back(model(inst, cyc));
    cmp("done_drop", {31'd0, done[inst]}, 32'd0);
    cmp("busy_rise", {31'd0, busy[inst]}, 32'd1);
    if (poke) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      pulse(inst);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    cmp("done_wait", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid(int inst, bit in_wait);
    int n;
    kick(inst);
    gen(0, -1, 1'b1, in_wait ? 0 : TMO + 8);
    rd_data[0] = 32'h1234_5678;
    pulse(inst);
    n = 0;
    if (in_wait) begin
      while (rd_idx < 2 && n < 100) begin
        @(negedge clock);
        n++;
      end
      cmp("reach_wait_ts", rd_idx, 32'd2);
      @(posedge clock); #2;
    end else begin
      repeat (3) @(posedge clock);
      #2;
      cmp("av_read_stalled", {31'd0, av_read[inst]}, 32'd1);
    end
    reset = 1'b1;
    #1;
    cmp("rst_av_read", {31'd0, av_read[inst]}, 32'd0);
    cmp("rst_busy", {31'd0, busy[inst]}, 32'd0);
    cmp("rst_done", {31'd0, done[inst]}, 32'd0);
    cmp("rst_id_word", id_word[inst], 32'd0);
    cmp("rst_retry", {28'd0, retry_cnt[inst]}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    m_id = '{32'd0, 32'd0};
    m_ts = '{32'd0, 32'd0};
  endtask

  initial begin
    int inst, tr;
    start[0] = 1'b0;
    start[1] = 1'b0;
    m_id = '{32'd0, 32'd0};
    m_ts = '{32'd0, 32'd0};
    for (int r = 0; r < 6; r++) begin
      rd_stall[r] = 0;
      rd_data[r] = 32'd0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      cmp("reset_busy", {31'd0, busy[i]}, 32'd0);
      cmp("reset_done", {31'd0, done[i]}, 32'd0);
      cmp("reset_pass", {31'd0, pass[i]}, 32'd0);
      cmp("reset_timeout", {31'd0, tmo[i]}, 32'd0);
      cmp("reset_av_read", {31'd0, av_read[i]}, 32'd0);
      cmp("reset_id_ts", id_word[i] | ts_word[i], 32'd0);
      cmp("reset_retry", {28'd0, retry_cnt[i]}, 32'd0);
    end
    reset = 1'b0;
    run(0, 0, -1, 1'b1, -1, 1'b0);
    run(0, 3, -1, 1'b1, -1, 1'b0);
    run(0, 1, -1, 1'b1, -1, 1'b0);
    run(0, 0, 0, 1'b1, -1, 1'b0);
    run(0, 0, -1, 1'b1, TMO - 1, 1'b0);
    run(0, 0, 3, 1'b1, -1, 1'b0);
    run(1, 0, -1, 1'b1, 3, 1'b1);
    run(1, 1, -1, 1'b0, -1, 1'b1);
    run(1, 3, -1, 1'b1, -1, 1'b0);
    repeat (40) begin
      inst = $urandom_range(0, 1);
      tr = -1;
      if ($urandom_range(0, 3) == 0) tr = int'($urandom_range(0, 5));
      run(inst, $urandom_range(0, 3), tr, 1'b0, -1, inst == 1);
    end
    reset_mid(1, 1'b1);
    run(1, 0, -1, 1'b1, -1, 1'b0);
    reset_mid(0, 1'b0);
    run(0, 0, -1, 1'b1, -1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
